// File: rtl/cpu65el02_muldiv_seq_pkg.sv
// 65EL02 MUL/DIV sequencer: shared state encoding,
// ALU op codes and iteration counts.
package cpu65el02_muldiv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  localparam logic [4:0] OP_MUL = 5'd15;
  localparam logic [4:0] OP_DIV = 5'd16;

  localparam int MUL_LAT_16 = 16;
  localparam int MUL_LAT_8  = 8;
  localparam int DIV_LAT_16 = 32;
  localparam int DIV_LAT_8  = 16;

endpackage

// File: rtl/cpu65el02_muldiv_seq_abs.sv
// Conditional two's-complement negate: magnitude of val,
// inverted again when flip is set; sign reports val's MSB.
module muldiv_abs #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  input  logic         flip,
  output logic [W-1:0] result,
  output logic         sign
);

  assign sign   = val[W-1];
  assign result = (sign ^ flip)
                ? (~val + {{(W-1){1'b0}}, 1'b1})
                : val;

endmodule

// File: rtl/cpu65el02_muldiv_seq.sv
// Multi-cycle signed MUL/DIV for the 65EL02 ALU:
// shift-add multiply, restoring divide, sign fix-up.
module cpu65el02_muldiv_seq
  import cpu65el02_muldiv_seq_pkg::*;
(
  input  logic        Clk,
  input  logic        nReset,
  input  logic        Start,
  input  logic        OpDiv,
  input  logic        Size,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] D,
  input  logic        Abort,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Y,
  output logic [15:0] YHi,
  output logic        OutFlagN,
  output logic        OutFlagZ,
  output logic        OutFlagV,
  output logic        OutFlagC
);

  state_t      state;
  logic        opDiv;
  logic        size;
  logic        signA;
  logic        signB;
  logic        divZero;
  logic [15:0] rawA;
  logic [15:0] rawB;
  logic [15:0] rawD;
  logic [15:0] opB;
  logic [15:0] rem;
  logic [31:0] opA;
  logic [31:0] res;
  logic [5:0]  cnt;

  logic [15:0] dvd8;
  logic [31:0] extA;
  logic [31:0] magA;
  logic [15:0] extB;
  logic [15:0] magB;
  logic        sgnA;
  logic        sgnB;
  logic [31:0] fixRes;
  logic [15:0] fixRem;
  logic        resTop;
  logic        qNeg;
  logic [31:0] limit;
  logic        divOvf;
  logic [16:0] shRem;
  logic [16:0] trial;

  assign dvd8 = {rawD[7:0], rawA[7:0]};

  assign extA = opDiv
              ? (size ? {{16{dvd8[15]}}, dvd8}
                      : {rawD, rawA})
              : (size ? {{24{rawA[7]}}, rawA[7:0]}
                      : {{16{rawA[15]}}, rawA});

  assign extB = size ? {{8{rawB[7]}}, rawB[7:0]}
                     : rawB;

  muldiv_abs #(.W(32)) uAbsA (
    .val   (extA),
    .flip  (1'b0),
    .result(magA),
    .sign  (sgnA)
  );

  muldiv_abs #(.W(16)) uAbsB (
    .val   (extB),
    .flip  (1'b0),
    .result(magB),
    .sign  (sgnB)
  );

  assign qNeg = signA ^ signB;

  // res holds a magnitude; only a 2^31 quotient sets
  // its MSB, and negating that value is a no-op anyway
  muldiv_abs #(.W(32)) uFix (
    .val   (res),
    .flip  (qNeg),
    .result(fixRes),
    .sign  (resTop)
  );

  assign fixRem = signA ? (~rem + 16'd1) : rem;

  // a negative quotient may reach one step further
  assign limit  = size ? 32'd128 : 32'd32768;
  assign divOvf = resTop
                | (qNeg ? (res > limit) : (res >= limit));

  assign shRem = {rem, res[31]};
  assign trial = shRem - {1'b0, opB};

  assign OutFlagC = 1'b0;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Y        <= '0;
      YHi      <= '0;
      OutFlagN <= 1'b0;
      OutFlagZ <= 1'b0;
      OutFlagV <= 1'b0;
      opDiv    <= 1'b0;
      size     <= 1'b0;
      signA    <= 1'b0;
      signB    <= 1'b0;
      divZero  <= 1'b0;
      rawA     <= '0;
      rawB     <= '0;
      rawD     <= '0;
      opA      <= '0;
      opB      <= '0;
      rem      <= '0;
      res      <= '0;
      cnt      <= '0;
    end else if (Abort && state != IDLE) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start && !Abort) begin
            opDiv <= OpDiv;
            size  <= Size;
            rawA  <= A;
            rawB  <= B;
            rawD  <= D;
            Busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          signA <= sgnA;
          signB <= sgnB;
          opB   <= magB;
          rem   <= '0;
          if (opDiv) begin
            opA     <= '0;
            res     <= size ? {magA[15:0], 16'h0000}
                            : magA;
            cnt     <= size ? 6'(DIV_LAT_8)
                            : 6'(DIV_LAT_16);
            divZero <= (magB == '0);
            state   <= (magB == '0) ? FIX : ITER;
          end else begin
            opA     <= magA;
            res     <= '0;
            cnt     <= size ? 6'(MUL_LAT_8)
                            : 6'(MUL_LAT_16);
            divZero <= 1'b0;
            state   <= ITER;
          end
        end
        ITER: begin
          if (opDiv) begin
            res <= {res[30:0], ~trial[16]};
            rem <= trial[16] ? shRem[15:0]
                             : trial[15:0];
          end else begin
            if (opB[0]) res <= res + opA;
            opA <= {opA[30:0], 1'b0};
            opB <= {1'b0, opB[15:1]};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= FIX;
        end
        FIX: begin
          if (divZero) begin
            Y        <= '0;
            YHi      <= size ? {8'h00, rawA[7:0]} : rawA;
            OutFlagN <= 1'b0;
            OutFlagZ <= 1'b1;
            OutFlagV <= 1'b1;
          end else if (opDiv) begin
            Y        <= size ? {8'h00, fixRes[7:0]}
                             : fixRes[15:0];
            YHi      <= size ? {8'h00, fixRem[7:0]}
                             : fixRem;
            OutFlagN <= size ? fixRes[7] : fixRes[15];
            OutFlagZ <= (res == '0);
            OutFlagV <= divOvf;
          end else begin
            Y        <= size ? {8'h00, fixRes[7:0]}
                             : fixRes[15:0];
            YHi      <= size ? {8'h00, fixRes[15:8]}
                             : fixRes[31:16];
            OutFlagN <= size ? fixRes[15] : fixRes[31];
            OutFlagZ <= (res == '0);
            OutFlagV <= 1'b0;
          end
          Busy  <= 1'b0;
          Done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu65el02_muldiv_seq.sv
// Self-checking bench for cpu65el02_muldiv_seq:
// scoreboard of reference results against DUT output.
module tb_cpu65el02_muldiv_seq;

  logic        Clk;
  logic        nReset;
  logic        Start;
  logic        OpDiv;
  logic        Size;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] D;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic [15:0] Y;
  logic [15:0] YHi;
  logic        OutFlagN;
  logic        OutFlagZ;
  logic        OutFlagV;
  logic        OutFlagC;

  typedef struct {
    logic [15:0] y;
    logic [15:0] yhi;
    logic [3:0]  f;
    int          lat;
  } res_t;

  res_t expQ[$];
  int   nCmp = 0;
  int   nErr = 0;

  cpu65el02_muldiv_seq dut (
    .Clk     (Clk),
    .nReset  (nReset),
    .Start   (Start),
    .OpDiv   (OpDiv),
    .Size    (Size),
    .A       (A),
    .B       (B),
    .D       (D),
    .Abort   (Abort),
    .Busy    (Busy),
    .Done    (Done),
    .Y       (Y),
    .YHi     (YHi),
    .OutFlagN(OutFlagN),
    .OutFlagZ(OutFlagZ),
    .OutFlagV(OutFlagV),
    .OutFlagC(OutFlagC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic res_t model(
    input bit div, input bit sz,
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] d);
    res_t   e;
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    bit     ovf;
    if (!div) begin
      sa = sz ? longint'($signed(a[7:0])) : longint'($signed(a));
      sb = sz ? longint'($signed(b[7:0])) : longint'($signed(b));
      p  = sa * sb;
      e.y   = sz ? {8'h00, p[7:0]}  : p[15:0];
      e.yhi = sz ? {8'h00, p[15:8]} : p[31:16];
      e.f   = {p < 0, p == 0, 1'b0, 1'b0};
      e.lat = sz ? 10 : 18;
    end else begin
      sa = sz ? longint'($signed({d[7:0], a[7:0]}))
              : longint'($signed({d, a}));
      sb = sz ? longint'($signed(b[7:0])) : longint'($signed(b));
      if (sb == 0) begin
        e.y   = 16'h0000;
        e.yhi = sz ? {8'h00, a[7:0]} : a;
        e.f   = 4'b0110;
        e.lat = 2;
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        ovf = sz ? (q > 127 || q < -128)
                 : (q > 32767 || q < -32768);
        e.y   = sz ? {8'h00, q[7:0]} : q[15:0];
        e.yhi = sz ? {8'h00, r[7:0]} : r[15:0];
        e.f   = {(sz ? q[7] : q[15]), q == 0, ovf, 1'b0};
        e.lat = sz ? 18 : 34;
      end
    end
    return e;
  endfunction

  task automatic runOp(
    input bit div, input bit sz,
    input logic [15:0] a, input logic [15:0] b,
    input logic [15:0] d, output res_t got);
    @(negedge Clk);
    if (Done) @(negedge Clk);
    OpDiv = div;
    Size  = sz;
    A     = a;
    B     = b;
    D     = d;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    got.lat = 0;
    while (Done !== 1'b1 && got.lat < 100) begin
      @(posedge Clk);
      #1;
      got.lat++;
    end
    got.y   = Y;
    got.yhi = YHi;
    got.f   = {OutFlagN, OutFlagZ, OutFlagV, OutFlagC};
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    Start  = 1'b0;
    Abort  = 1'b0;
    OpDiv  = 1'b0;
    Size   = 1'b0;
    A      = '0;
    B      = '0;
    D      = '0;
    #12;
    nCmp++;
    if (Busy !== 1'b0) begin
      nErr++;
      $display("FAIL reset Busy got %b exp 0", Busy);
    end
    nCmp++;
    if (Done !== 1'b0) begin
      nErr++;
      $display("FAIL reset Done got %b exp 0", Done);
    end
    nCmp++;
    if (Y !== 16'h0000 || YHi !== 16'h0000) begin
      nErr++;
      $display("FAIL reset Y/YHi got %h/%h exp 0000/0000", Y, YHi);
    end
    nCmp++;
    if ({OutFlagN, OutFlagZ, OutFlagV, OutFlagC} !== 4'b0000) begin
      nErr++;
      $display("FAIL reset flags got %b exp 0000",
               {OutFlagN, OutFlagZ, OutFlagV, OutFlagC});
    end
    @(negedge Clk);
    nReset = 1'b1;
  endtask

  task automatic test_mul;
    logic [15:0] ta[8];
    logic [15:0] tb[8];
    bit          ts[8];
    logic [15:0] a;
    logic [15:0] b;
    bit          sz;
    res_t        got;
    res_t        e;
    ta = '{16'hFFFD, 16'h0080, 16'h0000, 16'h8000,
           16'h007F, 16'h1234, 16'h7FFF, 16'hFFFF};
    tb = '{16'h0007, 16'h0080, 16'h5555, 16'h8000,
           16'h0081, 16'hFF00, 16'h7FFF, 16'h00FF};
    ts = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        a = ta[i]; b = tb[i]; sz = ts[i];
      end else begin
        a = 16'($urandom()); b = 16'($urandom());
        sz = 1'($urandom());
      end
      expQ.push_back(model(1'b0, sz, a, b, 16'h0000));
      runOp(1'b0, sz, a, b, 16'h0000, got);
      e = expQ.pop_front();
      nCmp++;
      if (got.y !== e.y) begin
        nErr++;
        $display("FAIL mul[%0d] Y got %h exp %h", i, got.y, e.y);
      end
      nCmp++;
      if (got.yhi !== e.yhi) begin
        nErr++;
        $display("FAIL mul[%0d] YHi got %h exp %h", i, got.yhi, e.yhi);
      end
      nCmp++;
      if (got.f !== e.f) begin
        nErr++;
        $display("FAIL mul[%0d] NZVC got %b exp %b", i, got.f, e.f);
      end
      nCmp++;
      if (got.lat != e.lat) begin
        nErr++;
        $display("FAIL mul[%0d] latency got %0d exp %0d",
                 i, got.lat, e.lat);
      end
    end
  endtask

  task automatic test_div;
    logic [15:0] td[8];
    logic [15:0] ta[8];
    logic [15:0] tb[8];
    bit          ts[8];
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] d;
    bit          sz;
    res_t        got;
    res_t        e;
    td = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000,
           16'h0000, 16'h0012, 16'h0000, 16'h1234};
    ta = '{16'hFFF9, 16'h8000, 16'h8000, 16'h00F9,
           16'h0080, 16'h3456, 16'h0064, 16'h5678};
    tb = '{16'h0002, 16'h0001, 16'hFFFF, 16'h00F9,
           16'h00FF, 16'h7FFF, 16'hFFF9, 16'h00FD};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        d = td[i]; a = ta[i]; b = tb[i]; sz = ts[i];
      end else begin
        d = 16'($urandom_range(0, 15)) - 16'd8;
        a = 16'($urandom());
        b = 16'($urandom()) | 16'h0101;
        sz = 1'($urandom());
      end
      expQ.push_back(model(1'b1, sz, a, b, d));
      runOp(1'b1, sz, a, b, d, got);
      e = expQ.pop_front();
      nCmp++;
      if (got.y !== e.y) begin
        nErr++;
        $display("FAIL div[%0d] Y got %h exp %h", i, got.y, e.y);
      end
      nCmp++;
      if (got.yhi !== e.yhi) begin
        nErr++;
        $display("FAIL div[%0d] YHi got %h exp %h", i, got.yhi, e.yhi);
      end
      nCmp++;
      if (got.f !== e.f) begin
        nErr++;
        $display("FAIL div[%0d] NZVC got %b exp %b", i, got.f, e.f);
      end
      nCmp++;
      if (got.lat != e.lat) begin
        nErr++;
        $display("FAIL div[%0d] latency got %0d exp %0d",
                 i, got.lat, e.lat);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [15:0] ta[3];
    logic [15:0] tb[3];
    bit          ts[3];
    res_t        got;
    res_t        e;
    ta = '{16'h1234, 16'hAB12, 16'h00F0};
    tb = '{16'h0000, 16'h0000, 16'h0100};
    ts = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(model(1'b1, ts[i], ta[i], tb[i], 16'h0000));
      runOp(1'b1, ts[i], ta[i], tb[i], 16'h0000, got);
      e = expQ.pop_front();
      nCmp++;
      if (got.y !== e.y || got.yhi !== e.yhi) begin
        nErr++;
        $display("FAIL divzero[%0d] Y/YHi got %h/%h exp %h/%h",
                 i, got.y, got.yhi, e.y, e.yhi);
      end
      nCmp++;
      if (got.f !== e.f) begin
        nErr++;
        $display("FAIL divzero[%0d] NZVC got %b exp %b", i, got.f, e.f);
      end
      nCmp++;
      if (got.lat != e.lat) begin
        nErr++;
        $display("FAIL divzero[%0d] latency got %0d exp %0d",
                 i, got.lat, e.lat);
      end
    end
  endtask

  task automatic test_overflow;
    logic [15:0] td[4];
    logic [15:0] ta[4];
    logic [15:0] tb[4];
    bit          ts[4];
    res_t        got;
    res_t        e;
    td = '{16'h0001, 16'h8000, 16'h0000, 16'h0000};
    ta = '{16'h0000, 16'h0000, 16'h8000, 16'h0080};
    tb = '{16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back(model(1'b1, ts[i], ta[i], tb[i], td[i]));
      runOp(1'b1, ts[i], ta[i], tb[i], td[i], got);
      e = expQ.pop_front();
      nCmp++;
      if (got.y !== e.y || got.yhi !== e.yhi) begin
        nErr++;
        $display("FAIL ovf[%0d] Y/YHi got %h/%h exp %h/%h",
                 i, got.y, got.yhi, e.y, e.yhi);
      end
      nCmp++;
      if (got.f !== e.f) begin
        nErr++;
        $display("FAIL ovf[%0d] NZVC got %b exp %b", i, got.f, e.f);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t got;
    res_t e;
    int   lat;
    expQ.push_back(model(1'b0, 1'b0, 16'h0321, 16'hFF10, 16'h0000));
    runOp(1'b0, 1'b0, 16'h0321, 16'hFF10, 16'h0000, got);
    e = expQ.pop_front();
    nCmp++;
    if (got.y !== e.y || got.yhi !== e.yhi || got.lat != e.lat) begin
      nErr++;
      $display("FAIL b2b_first got %h:%h/%0d exp %h:%h/%0d",
               got.yhi, got.y, got.lat, e.yhi, e.y, e.lat);
    end
    // still in the Done cycle here
    OpDiv = 1'b1;
    Size  = 1'b1;
    D     = 16'h00FF;
    A     = 16'h0085;
    B     = 16'h0009;
    Start = 1'b1;
    expQ.push_back(model(1'b1, 1'b1, 16'h0085, 16'h0009, 16'h00FF));
    @(posedge Clk);
    #1;
    nCmp++;
    if (Busy !== 1'b0) begin
      nErr++;
      $display("FAIL b2b_done_start Busy got %b exp 0", Busy);
    end
    @(posedge Clk);
    #1;
    Start = 1'b0;
    nCmp++;
    if (Busy !== 1'b1) begin
      nErr++;
      $display("FAIL b2b_accept Busy got %b exp 1", Busy);
    end
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge Clk);
      #1;
      lat++;
      if (lat == 2) begin
        OpDiv = 1'b0;
        A     = 16'h7FFF;
        B     = 16'h7FFF;
        Start = 1'b1;
      end else if (lat == 3) begin
        Start = 1'b0;
      end
    end
    e = expQ.pop_front();
    nCmp++;
    if (Y !== e.y || YHi !== e.yhi) begin
      nErr++;
      $display("FAIL b2b_second Y/YHi got %h/%h exp %h/%h",
               Y, YHi, e.y, e.yhi);
    end
    nCmp++;
    if ({OutFlagN, OutFlagZ, OutFlagV, OutFlagC} !== e.f) begin
      nErr++;
      $display("FAIL b2b_second NZVC got %b exp %b",
               {OutFlagN, OutFlagZ, OutFlagV, OutFlagC}, e.f);
    end
    nCmp++;
    if (lat != e.lat) begin
      nErr++;
      $display("FAIL b2b_second latency got %0d exp %0d", lat, e.lat);
    end
  endtask

  task automatic test_abort;
    res_t got;
    res_t e;
    res_t last;
    int   pulses;
    expQ.push_back(model(1'b0, 1'b0, 16'h0123, 16'h0011, 16'h0000));
    runOp(1'b0, 1'b0, 16'h0123, 16'h0011, 16'h0000, got);
    last = expQ.pop_front();
    nCmp++;
    if (got.y !== last.y || got.yhi !== last.yhi) begin
      nErr++;
      $display("FAIL abort_pre got %h:%h exp %h:%h",
               got.yhi, got.y, last.yhi, last.y);
    end
    @(negedge Clk);
    if (Done) @(negedge Clk);
    OpDiv = 1'b0;
    A     = 16'h4444;
    B     = 16'h0003;
    Start = 1'b1;
    Abort = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    Abort = 1'b0;
    nCmp++;
    if (Busy !== 1'b0) begin
      nErr++;
      $display("FAIL abort_idle_start Busy got %b exp 0", Busy);
    end
    @(negedge Clk);
    Size  = 1'b0;
    A     = 16'h7777;
    B     = 16'h3333;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    nCmp++;
    if (Busy !== 1'b1) begin
      nErr++;
      $display("FAIL abort_iter5 Busy got %b exp 1", Busy);
    end
    @(negedge Clk);
    Abort = 1'b1;
    @(posedge Clk);
    #1;
    Abort = 1'b0;
    nCmp++;
    if (Busy !== 1'b0) begin
      nErr++;
      $display("FAIL abort_busy_drop Busy got %b exp 0", Busy);
    end
    pulses = Done ? 1 : 0;
    repeat (25) begin
      @(posedge Clk);
      #1;
      if (Done) pulses++;
    end
    nCmp++;
    if (pulses != 0) begin
      nErr++;
      $display("FAIL abort_no_done pulses got %0d exp 0", pulses);
    end
    nCmp++;
    if (Y !== last.y || YHi !== last.yhi) begin
      nErr++;
      $display("FAIL abort_hold Y/YHi got %h/%h exp %h/%h",
               Y, YHi, last.y, last.yhi);
    end
    nCmp++;
    if ({OutFlagN, OutFlagZ, OutFlagV, OutFlagC} !== last.f) begin
      nErr++;
      $display("FAIL abort_hold NZVC got %b exp %b",
               {OutFlagN, OutFlagZ, OutFlagV, OutFlagC}, last.f);
    end
    expQ.push_back(model(1'b0, 1'b0, 16'hC001, 16'h0BCD, 16'h0000));
    runOp(1'b0, 1'b0, 16'hC001, 16'h0BCD, 16'h0000, got);
    e = expQ.pop_front();
    nCmp++;
    if (got.y !== e.y || got.yhi !== e.yhi) begin
      nErr++;
      $display("FAIL abort_after Y/YHi got %h/%h exp %h/%h",
               got.y, got.yhi, e.y, e.yhi);
    end
    nCmp++;
    if (got.f !== e.f || got.lat != e.lat) begin
      nErr++;
      $display("FAIL abort_after NZVC/lat got %b/%0d exp %b/%0d",
               got.f, got.lat, e.f, e.lat);
    end
  endtask

  task automatic test_nreset;
    int pulses;
    @(negedge Clk);
    if (Done) @(negedge Clk);
    OpDiv = 1'b1;
    Size  = 1'b0;
    D     = 16'h0000;
    A     = 16'h0064;
    B     = 16'h0007;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    #3;
    nReset = 1'b0;
    #1;
    nCmp++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      nErr++;
      $display("FAIL nreset Busy/Done got %b/%b exp 0/0", Busy, Done);
    end
    nCmp++;
    if (Y !== 16'h0000 || YHi !== 16'h0000) begin
      nErr++;
      $display("FAIL nreset Y/YHi got %h/%h exp 0000/0000", Y, YHi);
    end
    nCmp++;
    if ({OutFlagN, OutFlagZ, OutFlagV, OutFlagC} !== 4'b0000) begin
      nErr++;
      $display("FAIL nreset flags got %b exp 0000",
               {OutFlagN, OutFlagZ, OutFlagV, OutFlagC});
    end
    @(negedge Clk);
    nReset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (Done) pulses++;
    end
    nCmp++;
    if (pulses != 0 || Busy !== 1'b0) begin
      nErr++;
      $display("FAIL nreset_no_done pulses/Busy got %0d/%b exp 0/0",
               pulses, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_nreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/cpu65el02_muldiv_seq.md
Name: cpu65el02_muldiv_seq

Overview:
Multi-cycle sequencer for the 65EL02 MUL and DIV operations, ALU op codes 15 and 16. The single-cycle ALU handles all other ops.
- The block takes the operands (B and the D:A pair) on a Start handshake.
- It runs a shift-add signed multiply or a restoring signed divide over N cycles, then applies sign correction.
- It presents the results and the flags with the same meaning as the ALU flag outputs.
- The CPU core stalls on Busy and writes Y to A and YHi to D when Done pulses.

Parameters:
- MUL_LAT_16, 16, iteration count for a 16-bit multiply (8-bit uses 8).
- DIV_LAT_16, 32, iteration count for a 16-bit divide (8-bit uses 16).

Ports:
- Clk  in  1  clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  begin operation. Sampled only in IDLE.
- OpDiv  in  1  0 = MUL, 1 = DIV.
- Size  in  1  1 = 8-bit (M/X flag set), 0 = 16-bit.
- A  in  16  multiplicand, or low dividend.
- B  in  16  multiplier, or divisor.
- D  in  16  high dividend (DIV only).
- Abort  in  1  synchronous cancel (interrupt or pipeline flush).
- Busy  out  1  high from the edge after Start is accepted until Done.
- Done  out  1  one-cycle pulse; results are valid in this cycle and held afterwards.
- Y  out  16  MUL: low product. DIV: quotient.
- YHi  out  16  MUL: high product. DIV: remainder.
- OutFlagN, OutFlagZ, OutFlagV, OutFlagC  out  1 each.

Behaviour:
- Reset: all state is cleared. State=IDLE; Busy, Done, Y, YHi and all flags are 0. nReset asserted mid-operation aborts it, and Done never pulses for that operation.
- States and transitions: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: if Start, latch OpDiv, Size, A, B, D, then go to PREP.
- PREP (1 cycle):
  - Take the absolute values of the operands and record their signs.
  - 8-bit mode sign-extends A[7:0] and B[7:0]. The 8-bit dividend is {D[7:0], A[7:0]}, sign-extended.
  - Load the iteration counter: N = 16/8 for MUL and 32/16 for DIV.
  - If DIV and the divisor is 0, go directly to FIX with the divide-by-zero flag set.
- ITER (N cycles): one shift-add or shift-subtract step per cycle. The counter decrements and the state leaves on count = 1.
- FIX (1 cycle):
  - Negate the product if signA ^ signB.
  - Negate the quotient if signA ^ signB; the remainder takes the sign of the dividend, so division truncates toward zero.
  - Register Y, YHi and the flags.
- DONE (1 cycle): Done = 1, Busy = 0, then go to IDLE. Start in the DONE cycle is ignored; Start in IDLE in the following cycle is accepted.
- Latency: Done is high in the cycle after N+2 edges following the edge that samples Start. That is 18/10 cycles for MUL16/MUL8, 34/18 for DIV16/DIV8, and 2 for divide by zero.
- 8-bit mode results:
  - MUL: Y = {8'h00, product[7:0]}, YHi = {8'h00, product[15:8]}.
  - DIV: Y = {8'h00, q[7:0]}, YHi = {8'h00, r[7:0]}.
- Flags:
  - MUL: N = sign bit of the full product (bit 31, or bit 15 in 8-bit mode). Z = full product == 0. V = 0.
  - DIV: N = quotient sign bit at the operating width. Z = quotient == 0. V = divide by zero, or quotient outside the signed range of the operating width.
  - C = 0 always.
- Divide by zero: Y = 0, YHi = A (masked to 8 bits in 8-bit mode), V = 1, Z = 1, N = 0.
- Quotient overflow: Y and YHi hold the truncated low bits, and V = 1.
- Start while Busy is ignored. Inputs are don't-care after PREP.
- Abort (any state other than IDLE): go to IDLE on the next edge. Busy falls, no Done pulse, and Y, YHi and the flags keep their previous values. Abort in IDLE has no effect; Abort together with Start in IDLE means Abort wins.
- Outputs hold their values between operations.

Decomposition:
- Shared package: state encoding (IDLE, PREP, ITER, FIX, DONE), the ALU op code constants OP_MUL = 15 and OP_DIV = 16, and the iteration-count constants.
- One natural sub-module: muldiv_abs, a width-parameterised absolute value with sign output, shared by the operand path and the FIX negation path.

Test Plan:
- MUL16, A = 0xFFFD, B = 0x0007, Size = 0 -> Done after 18 edges, YHi:Y = 0xFFFF:0xFFEB, N = 1, Z = 0, V = 0.
- MUL8, A = 0x0080, B = 0x0080, Size = 1 -> Done after 10 edges, Y = 0x0000, YHi = 0x0040, N = 0, Z = 0.
- DIV16, D = 0xFFFF, A = 0xFFF9, B = 0x0002 -> Done after 34 edges, Y = 0xFFFD, YHi = 0xFFFF, N = 1, V = 0.
- DIV by zero, D = 0x0000, A = 0x1234, B = 0x0000 -> Done after 2 edges, Y = 0x0000, YHi = 0x1234, V = 1, Z = 1.
- DIV16 overflow, D = 0x0001, A = 0x0000, B = 0x0001 -> Y = 0x0000, YHi = 0x0000, V = 1.
- Interrupted operations:
  - Abort at ITER cycle 5 -> Busy = 0 next cycle, no Done pulse, outputs unchanged.
  - A new MUL started afterwards completes correctly.
  - nReset pulsed mid-DIV -> all outputs are 0 immediately.
